// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency single-port data memory responder with range checking.
// Define DMEM_RESPONDER_ALIGN_CHECK_EN to also flag misaligned addresses as errors.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;
  logic          r_we;
  logic [29:0]   r_widx;
  logic [31:0]   r_wdata;
  logic [31:0]   r_mem [DEPTH_WORDS];
  logic          w_accept;
  logic          w_resp;
  logic          w_oob;
  logic          w_misalign;
  logic          w_err;
  logic [AW-1:0] w_idx;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_widx  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we    <= we_i;
        r_widx  <= addr_i[31:2];
        r_wdata <= data_i;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_i) begin
          w_accept = 1'b1;
          if (LATENCY <= 1) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = S_RESP;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
  logic r_misalign;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         r_misalign <= 1'b0;
    else if (w_accept) r_misalign <= |addr_i[1:0];
  end
  assign w_misalign = r_misalign;
`else
  logic w_unused_addr_lo;
  assign w_unused_addr_lo = ^addr_i[1:0];
  assign w_misalign       = 1'b0;
`endif

  assign w_resp = (r_state == S_RESP);
  assign w_oob  = (32'(r_widx) >= DEPTH_WORDS);
  assign w_err  = w_oob | w_misalign;
  assign w_idx  = r_widx[AW-1:0];

  // Storage has no reset; reset forces IDLE so an in-flight store never commits.
  always_ff @(posedge clk_i) begin
    if (w_resp && r_we && !w_err) r_mem[w_idx] <= r_wdata;
  end

  assign ack_o   = w_resp;
  assign err_o   = w_resp & w_err;
  assign data_o  = (w_resp && !r_we && !w_err) ? r_mem[w_idx] : '0;
  assign stall_o = (r_state == S_WAIT) | ((r_state == S_IDLE) & req_i);

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit storage words.
REQ-002 The block SHALL have parameter LATENCY, default 4: cycles from request acceptance to ack; legal range 1..15.
REQ-003 The block SHALL have port clk_i  input  1  sole clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port req_i  input  1  requester asserts and holds until ack_o.
REQ-006 The block SHALL have port we_i  input  1  1 = store, 0 = load; sampled with req_i.
REQ-007 The block SHALL have port addr_i  input  32  byte address; word index = addr_i[31:2].
REQ-008 The block SHALL have port data_i  input  32  store data.
REQ-009 The block SHALL have port data_o  output  32  load data; valid only while ack_o=1.
REQ-010 The block SHALL have port ack_o  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have port err_o  output  1  error qualifier; meaningful only while ack_o=1.
REQ-012 The block SHALL have port stall_o  output  1  pipeline hold to requester.

Function
REQ-013 FSM states SHALL be IDLE, WAIT, RESP, encoded in 2 bits.
REQ-014 In IDLE with req_i=1, the next edge SHALL latch we_i, addr_i, data_i and go to WAIT, or to RESP directly if LATENCY=1.
REQ-015 WAIT SHALL load a 4-bit down-counter with LATENCY-2 on entry, decrement each cycle, and go to RESP when it reaches 0.
REQ-016 ack_o SHALL be 1 for exactly the one cycle in RESP: a request accepted at edge N gives ack_o high in the cycle after edge N+LATENCY-1.
REQ-017 RESP SHALL always return to IDLE on the next edge; if req_i is still 1 in that IDLE cycle, it SHALL be accepted as a new request.
REQ-018 stall_o SHALL equal (state!=IDLE) OR (state==IDLE AND req_i), combinationally, with ack cycle excluded (stall_o=0 in RESP).
REQ-019 Changes to req_i, we_i, addr_i or data_i outside IDLE SHALL be ignored; latched values SHALL govern the access.
REQ-020 A store SHALL write memory at the edge leaving RESP; a load SHALL drive the latched word combinationally on data_o during RESP.
REQ-021 Word index >= DEPTH_WORDS SHALL give err_o=1 with ack_o, data_o=0, and no write.
REQ-022 data_o SHALL be 0 whenever ack_o=0.
REQ-023 A load in RESP SHALL see all stores completed at earlier edges; back-to-back store then load to the same word SHALL return the stored value.

Reset
REQ-024 Asserting rst_i SHALL force state IDLE, counter 0, latched request cleared, ack_o=0, err_o=0, data_o=0 immediately, independent of clk_i.
REQ-025 Reset mid-operation SHALL abort the access with no ack and no memory write; storage contents SHALL NOT be cleared by reset.
REQ-026 First request SHALL be accepted on the first rising edge after rst_i deasserts.

Configuration
REQ-027 Macro DMEM_RESPONDER_ALIGN_CHECK_EN SHALL control misalignment checking.
REQ-028 With the macro defined, addr_i[1:0]!=0 SHALL produce ack_o with err_o=1, data_o=0, no write, and the same latency as a normal access.
REQ-029 Without the macro, addr_i[1:0] SHALL be ignored, and err_o SHALL reflect only the out-of-range condition.

Verification
REQ-030 LATENCY=4: store 0xDEADBEEF to 0x10 at edge N -> ack_o in the cycle after edge N+3; load 0x10 -> data_o=0xDEADBEEF, err_o=0.
REQ-031 LATENCY=1: req_i held high for back-to-back load/load -> ack_o every second cycle, stall_o=0 only in ack cycles.
REQ-032 Address 0x400 with DEPTH_WORDS=256 -> ack_o with err_o=1, data_o=0; a later load of 0x0 is unchanged.
REQ-033 rst_i pulse two cycles into a store to 0x20 -> no ack_o; a subsequent load of 0x20 returns the pre-store value.
REQ-034 Macro defined, store to 0x22 -> err_o=1 and no write; macro undefined -> word 0x20 written.
REQ-035 Change addr_i and data_i during WAIT -> access completes using the values latched at acceptance.
